// File: rtl/exhaustive_sweep_capture.sv
// Exhaustive stimulus engine: walks every N_IN-bit pattern (binary or Gray order),
// samples the DUT response after a settle delay, folds it into a MISR and streams records.
module exhaustive_sweep_capture #(
  parameter int               N_IN   = 6,
  parameter int               N_OUT  = 1,
  parameter int               SETTLE = 1,
  parameter int               GRAY   = 0,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h8016,
  parameter logic [SIG_W-1:0] SEED   = '0
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   pat_out,
  input  logic [N_OUT-1:0]  resp_in,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [N_IN-1:0]   rec_pattern,
  output logic [N_OUT-1:0]  rec_resp,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     ones_cnt
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    ONES_ONE = (N_IN + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RECORD, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [N_IN-1:0]    idx_reg, idx_inc, pat_inc, pat_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SIG_W-1:0]   sig_reg, sig_next, resp_ext;
  logic [N_IN:0]      ones_reg;
  logic [N_IN-1:0]    rec_pattern_reg;
  logic [N_OUT-1:0]   rec_resp_reg;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               valid_reg, valid_next;
  logic               start_go, advance, last_idx;

  assign start_go = (state_reg == S_IDLE) && start && !abort;
  assign advance  = (state_reg == S_RECORD) && rec_ready && !abort;
  assign last_idx = (idx_reg == '1);
  assign idx_inc  = idx_reg + IDX_ONE;

  // Pattern for the next index, Gray-coded bit by bit when GRAY is set
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_pat_bit
      if (GRAY != 0 && gi < N_IN - 1) begin : g_gray
        assign pat_inc[gi] = idx_inc[gi] ^ idx_inc[gi+1];
      end else begin : g_bin
        assign pat_inc[gi] = idx_inc[gi];
      end
    end
  endgenerate

  always_comb begin
    resp_ext = '0;
    resp_ext[N_OUT-1:0] = resp_in;
    sig_next = {sig_reg[SIG_W-2:0], ^(sig_reg & POLY)} ^ resp_ext;
  end

  // State register; status outputs are registered alongside it
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:   if (start) state_next = S_SETTLE;
        S_SETTLE: if (cnt_reg == '0) state_next = S_RECORD;
        S_RECORD: if (rec_ready) state_next = last_idx ? S_DONE : S_SETTLE;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_next  = (state_next == S_SETTLE) || (state_next == S_RECORD);
    done_next  = (state_next == S_DONE);
    valid_next = (state_next == S_RECORD);
  end

  // Datapath: abort freezes everything in place for the cycle it is seen
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      idx_reg         <= '0;
      pat_reg         <= '0;
      cnt_reg         <= '0;
      sig_reg         <= SEED;
      ones_reg        <= '0;
      rec_pattern_reg <= '0;
      rec_resp_reg    <= '0;
    end else if (!abort) begin
      if (start_go) begin
        idx_reg  <= '0;
        pat_reg  <= '0;
        cnt_reg  <= CNT_LOAD;
        sig_reg  <= SEED;
        ones_reg <= '0;
      end else if (state_reg == S_SETTLE) begin
        if (cnt_reg == '0) begin
          rec_resp_reg    <= resp_in;
          rec_pattern_reg <= pat_reg;
          sig_reg         <= sig_next;
          if (|resp_in) ones_reg <= ones_reg + ONES_ONE;
        end else begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
      end else if (advance && !last_idx) begin
        idx_reg <= idx_inc;
        pat_reg <= pat_inc;
        cnt_reg <= CNT_LOAD;
      end
    end
  end

  assign pat_out     = pat_reg;
  assign rec_valid   = valid_reg;
  assign rec_pattern = rec_pattern_reg;
  assign rec_resp    = rec_resp_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign signature   = sig_reg;
  assign ones_cnt    = ones_reg;

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: two configurations, a table-driven DUT response,
// and a reference model that recomputes records, counts and MISR from the sweep rules.
module tb_exhaustive_sweep_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic [1:0] start_v = '0, abort_v = '0, ready_v = 2'b11, rstn_v = '0;
  logic [2:0] resp_tbl [2][64];

  // instance 0: N_IN=2, binary, SETTLE=1, 4-bit MISR
  logic [1:0] pat0, rpat0;
  logic [0:0] resp0, rresp0;
  logic [3:0] sig0;
  logic [2:0] ones0;
  logic       valid0, busy0, done0;
  // instance 1: N_IN=6, Gray, SETTLE=3, 16-bit MISR
  logic [5:0] pat1, rpat1;
  logic [2:0] resp1, rresp1;
  logic [15:0] sig1;
  logic [6:0] ones1;
  logic       valid1, busy1, done1;

  always_comb begin
    resp0 = resp_tbl[0][int'(pat0)][0];
    resp1 = resp_tbl[1][int'(pat1)];
  end

  exhaustive_sweep_capture #(.N_IN(2), .N_OUT(1), .SETTLE(1), .GRAY(0), .SIG_W(4),
                             .POLY(4'b1001), .SEED(4'h0)) dut0 (
    .CK(CK), .reset(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .pat_out(pat0), .resp_in(resp0), .rec_valid(valid0), .rec_ready(ready_v[0]),
    .rec_pattern(rpat0), .rec_resp(rresp0), .busy(busy0), .done(done0),
    .signature(sig0), .ones_cnt(ones0));

  exhaustive_sweep_capture #(.N_IN(6), .N_OUT(3), .SETTLE(3), .GRAY(1), .SIG_W(16),
                             .POLY(16'h8016), .SEED(16'h1234)) dut1 (
    .CK(CK), .reset(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .pat_out(pat1), .resp_in(resp1), .rec_valid(valid1), .rec_ready(ready_v[1]),
    .rec_pattern(rpat1), .rec_resp(rresp1), .busy(busy1), .done(done1),
    .signature(sig1), .ones_cnt(ones1));

  logic [1:0]  valid_v, busy_v, done_v;
  logic [5:0]  pat_w [2];
  logic [5:0]  rpat_w [2];
  logic [2:0]  rresp_w [2];
  logic [15:0] sig_w [2];
  logic [6:0]  ones_w [2];
  assign valid_v = {valid1, valid0};
  assign busy_v  = {busy1, busy0};
  assign done_v  = {done1, done0};
  assign pat_w[0] = {4'b0, pat0};     assign pat_w[1] = pat1;
  assign rpat_w[0] = {4'b0, rpat0};   assign rpat_w[1] = rpat1;
  assign rresp_w[0] = {2'b0, rresp0}; assign rresp_w[1] = rresp1;
  assign sig_w[0] = {12'b0, sig0};    assign sig_w[1] = sig1;
  assign ones_w[0] = {4'b0, ones0};   assign ones_w[1] = ones1;

  int cfg_n      [2] = '{2, 6};
  int cfg_settle [2] = '{1, 3};
  int cfg_gray   [2] = '{0, 1};
  int cfg_nout   [2] = '{1, 3};
  int cfg_sigw   [2] = '{4, 16};
  logic [31:0] cfg_poly [2] = '{32'h9, 32'h8016};
  logic [31:0] cfg_seed [2] = '{32'h0, 32'h1234};

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // k-th pattern of the sweep
  function automatic int enc(input int d, input int k);
    return (cfg_gray[d] != 0) ? (k ^ (k >> 1)) : k;
  endfunction

  // MISR value after the first m responses of the sweep
  function automatic logic [31:0] model_sig(input int d, input int m);
    logic [31:0] s, mask;
    logic fb;
    mask = (32'd1 << cfg_sigw[d]) - 32'd1;
    s = cfg_seed[d];
    for (int k = 0; k < m; k++) begin
      fb = ^(s & cfg_poly[d]);
      s = ((s << 1) | {31'b0, fb}) & mask;
      s = s ^ {29'b0, resp_tbl[d][enc(d, k)]};
    end
    return s;
  endfunction

  function automatic int model_ones(input int d, input int m);
    int c = 0;
    for (int k = 0; k < m; k++) if (resp_tbl[d][enc(d, k)] != 0) c++;
    return c;
  endfunction

  task automatic check_reset(input int d);
    chk("rst_pat_out", pat_w[d], 0);
    chk("rst_rec_valid", valid_v[d], 0);
    chk("rst_rec_pattern", rpat_w[d], 0);
    chk("rst_rec_resp", rresp_w[d], 0);
    chk("rst_busy", busy_v[d], 0);
    chk("rst_done", done_v[d], 0);
    chk("rst_signature", sig_w[d], cfg_seed[d]);
    chk("rst_ones_cnt", ones_w[d], 0);
  endtask

  // tbl_mode: 0 random, 1 pat[0], 2 constant 1, 3 parity of pattern
  // stall_mode: 0 ready always, 1 five-cycle stall on record 3, 2 random ready and stray starts
  task automatic run_sweep(input int d, input int tbl_mode, input int stall_mode,
                           input int abort_at, input int reset_at);
    int n, s, total, k, cyc, stalls, st3, limit, seen_k;
    bit fin, saw_done;
    n = cfg_n[d];
    s = cfg_settle[d];
    total = 1 << n;
    limit = total * (s + 1) * 4 + 100;
    for (int p = 0; p < 64; p++) begin
      logic [5:0] pv;
      pv = 6'(p);
      case (tbl_mode)
        0:       resp_tbl[d][p] = 3'($urandom) & 3'((1 << cfg_nout[d]) - 1);
        1:       resp_tbl[d][p] = {2'b0, pv[0]};
        2:       resp_tbl[d][p] = 3'd1;
        default: resp_tbl[d][p] = {2'b0, ^pv};
      endcase
    end
    start_v[d] = 1'b1;
    ready_v[d] = 1'b1;
    @(posedge CK); #1;
    start_v[d] = 1'b0;
    cyc = 0;
    chk("busy_after_start", busy_v[d], 1);
    chk("sig_seed_at_start", sig_w[d], cfg_seed[d]);
    chk("ones_zero_at_start", ones_w[d], 0);
    chk("first_pat_out", pat_w[d], 0);
    k = 0; stalls = 0; st3 = 0; seen_k = -1; fin = 0;
    while (!fin) begin
      if (cyc > limit) begin
        chk("sweep_timeout", cyc, limit);
        fin = 1;
      end else if (done_v[d]) begin
        chk("done_edge", cyc, total * (s + 1) + stalls);
        chk("record_count", k, total);
        chk("busy_at_done", busy_v[d], 0);
        chk("valid_at_done", valid_v[d], 0);
        chk("final_signature", sig_w[d], model_sig(d, total));
        chk("final_ones_cnt", ones_w[d], model_ones(d, total));
        start_v[d] = 1'b0;
        ready_v[d] = 1'b1;
        @(posedge CK); #1;
        chk("done_one_cycle", done_v[d], 0);
        chk("signature_held", sig_w[d], model_sig(d, total));
        fin = 1;
      end else begin
        if (valid_v[d]) begin
          if (k != seen_k) begin
            chk("valid_edge", cyc, k * (s + 1) + s + stalls);
            seen_k = k;
          end
          chk("rec_pattern", rpat_w[d], enc(d, k));
          chk("rec_resp", rresp_w[d], resp_tbl[d][enc(d, k)]);
          chk("pat_out_stable", pat_w[d], enc(d, k));
          chk("busy_in_record", busy_v[d], 1);
          if (k == abort_at) begin
            abort_v[d] = 1'b1;
            ready_v[d] = 1'b1;
            @(posedge CK); #1;
            abort_v[d] = 1'b0;
            chk("abort_valid_drop", valid_v[d], 0);
            chk("abort_busy_drop", busy_v[d], 0);
            chk("abort_no_done", done_v[d], 0);
            chk("abort_sig_hold", sig_w[d], model_sig(d, k + 1));
            chk("abort_ones_hold", ones_w[d], model_ones(d, k + 1));
            chk("abort_pat_hold", pat_w[d], enc(d, k));
            saw_done = 0;
            repeat (3) begin
              @(posedge CK); #1;
              saw_done |= done_v[d];
            end
            chk("abort_never_done", saw_done, 0);
            start_v[d] = 1'b1;
            abort_v[d] = 1'b1;
            @(posedge CK); #1;
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            chk("start_abort_idle_busy", busy_v[d], 0);
            chk("start_abort_idle_sig", sig_w[d], model_sig(d, k + 1));
            fin = 1;
          end else if (k == reset_at) begin
            rstn_v[d] = 1'b0;
            #1;
            check_reset(d);
            @(posedge CK); #1;
            chk("reset_hold_valid", valid_v[d], 0);
            rstn_v[d] = 1'b1;
            fin = 1;
          end else begin
            case (stall_mode)
              0: ready_v[d] = 1'b1;
              1: begin
                if (k == 3 && st3 < 5) begin
                  ready_v[d] = 1'b0;
                  st3++;
                end else begin
                  ready_v[d] = 1'b1;
                end
              end
              default: begin
                ready_v[d] = ($urandom_range(0, 3) != 0);
                start_v[d] = ($urandom_range(0, 7) == 0);
              end
            endcase
            if (ready_v[d]) k++;
            else stalls++;
          end
        end else if (stall_mode >= 2) begin
          ready_v[d] = ($urandom_range(0, 1) != 0);
          start_v[d] = ($urandom_range(0, 7) == 0);
        end
        if (!fin) begin
          @(posedge CK); #1;
          cyc++;
        end
      end
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    $display("sweep inst=%0d tbl=%0d stall=%0d abort_at=%0d reset_at=%0d records=%0d cycles=%0d",
             d, tbl_mode, stall_mode, abort_at, reset_at, k, cyc);
  endtask

  initial begin
    rstn_v = 2'b00;
    repeat (3) @(posedge CK);
    #1;
    check_reset(0);
    check_reset(1);
    rstn_v = 2'b11;
    @(posedge CK); #1;

    run_sweep(0, 1, 0, -1, -1);
    chk("tp_ones_pat0", ones_w[0], 2);
    run_sweep(0, 2, 0, -1, -1);
    chk("tp_misr_final", sig_w[0], 32'hA);
    run_sweep(0, 0, 1, -1, -1);
    run_sweep(0, 0, 2, -1, -1);

    run_sweep(1, 3, 0, -1, -1);
    chk("tp_ones_xor", ones_w[1], 32);
    run_sweep(1, 0, 2, -1, -1);
    run_sweep(1, 0, 0, 10, -1);
    run_sweep(1, 0, 0, -1, 10);
    run_sweep(1, 0, 0, -1, -1);
    run_sweep(1, 0, 2, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
